// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer driving spi_master: command, 24-bit address, dummy clocks, buffered data.
// Optional macro SPI_FLASH_FASTREAD_EN selects fast-read (0x0B plus one dummy byte).
module spi_flash_reader #(
    parameter int NUM_TARGETS  = 1,
    parameter int FLASH_TARGET = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start_i,
    input  logic [23:0]            addr_i,
    input  logic [15:0]            len_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [7:0]             data_o,
    output logic                   data_valid_o,
    input  logic                   data_ready_i,
    output logic [NUM_TARGETS-1:0] spm_target_id_o,
    output logic                   spm_target_en_o,
    output logic [7:0]             spm_tx_byte_o,
    output logic                   spm_tx_en_o,
    input  logic                   spm_tx_ready_i,
    input  logic [7:0]             spm_rx_byte_i,
    input  logic                   spm_rx_en_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_AD2    = 3'd2,
        S_AD1    = 3'd3,
        S_AD0    = 3'd4,
        S_DUMMY  = 3'd5,
        S_DATA   = 3'd6,
        S_FINISH = 3'd7
    } state_t;

`ifdef SPI_FLASH_FASTREAD_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
    localparam state_t     AFTER_AD0 = S_DUMMY;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
    localparam state_t     AFTER_AD0 = S_DATA;
`endif

    state_t      state_q, state_d;
    logic        wait_q, wait_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] remain_q, remain_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cs_q, cs_d;
    logic        tx_en;
    logic [7:0]  tx_byte;
    logic        byte_state;
    logic        drain_ok;
    logic        issue_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wait_q   <= 1'b0;
            addr_q   <= 24'h0;
            remain_q <= 16'h0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_q     <= cs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        data_d     = data_q;
        valid_d    = valid_q & ~data_ready_i;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_d       = cs_q;
        tx_en      = 1'b0;
        tx_byte    = 8'h00;
        byte_state = 1'b0;
        drain_ok   = ~valid_q | data_ready_i;

        case (state_q)
            S_CMD:   begin tx_byte = READ_CMD;       byte_state = 1'b1; end
            S_AD2:   begin tx_byte = addr_q[23:16];  byte_state = 1'b1; end
            S_AD1:   begin tx_byte = addr_q[15:8];   byte_state = 1'b1; end
            S_AD0:   begin tx_byte = addr_q[7:0];    byte_state = 1'b1; end
            S_DUMMY: begin tx_byte = 8'h00;          byte_state = 1'b1; end
            S_DATA:  begin tx_byte = 8'h00;          byte_state = 1'b1; end
            default: begin tx_byte = 8'h00;          byte_state = 1'b0; end
        endcase

        // A data-phase dummy byte may only go out when its result has somewhere to land.
        issue_ok = (state_q == S_DATA) ? drain_ok : 1'b1;

        if (byte_state && !wait_q) begin
            tx_en = spm_tx_ready_i & issue_ok;
            if (tx_en) wait_d = 1'b1;
        end

        if (byte_state && wait_q && spm_rx_en_i) begin
            wait_d = 1'b0;
            case (state_q)
                S_CMD:   state_d = S_AD2;
                S_AD2:   state_d = S_AD1;
                S_AD1:   state_d = S_AD0;
                S_AD0:   state_d = AFTER_AD0;
                S_DUMMY: state_d = S_DATA;
                S_DATA: begin
                    data_d   = spm_rx_byte_i;
                    valid_d  = 1'b1;
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        cs_d    = 1'b0;
                        state_d = S_FINISH;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == 16'd0) begin
                        // Nothing to fetch: complete immediately without selecting the flash.
                        done_d = 1'b1;
                    end else begin
                        addr_d   = addr_i;
                        remain_d = len_i;
                        busy_d   = 1'b1;
                        cs_d     = 1'b1;
                        wait_d   = 1'b0;
                        state_d  = S_CMD;
                    end
                end
            end
            S_FINISH: begin
                if (drain_ok) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (abort_i && state_q != S_IDLE) begin
            tx_en    = 1'b0;
            state_d  = S_IDLE;
            wait_d   = 1'b0;
            remain_d = 16'd0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            cs_d     = 1'b0;
            done_d   = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
            spm_target_id_o[i] = (i == FLASH_TARGET);
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign data_o          = data_q;
    assign data_valid_o    = valid_q;
    assign spm_target_en_o = cs_q;
    assign spm_tx_en_o     = tx_en;
    assign spm_tx_byte_o   = tx_byte;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: random-latency spi_master model, consumer with backpressure,
// and a byte-level reference of the expected MOSI stream and delivered data.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FASTREAD_EN
    localparam int         HDR = 5;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] CMD = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic [23:0] addr_i;
    logic [15:0] len_i;
    logic        abort_i;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        data_ready_i = 1'b0;
    logic [1:0]  spm_target_id_o;
    logic        spm_target_en_o;
    logic [7:0]  spm_tx_byte_o;
    logic        spm_tx_en_o;
    logic        spm_tx_ready_i = 1'b0;
    logic [7:0]  spm_rx_byte_i = 8'h00;
    logic        spm_rx_en_i = 1'b0;

    spi_flash_reader #(.NUM_TARGETS(2), .FLASH_TARGET(1)) dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .data_o(data_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .spm_target_id_o(spm_target_id_o), .spm_target_en_o(spm_target_en_o),
        .spm_tx_byte_o(spm_tx_byte_o), .spm_tx_en_o(spm_tx_en_o),
        .spm_tx_ready_i(spm_tx_ready_i), .spm_rx_byte_i(spm_rx_byte_i),
        .spm_rx_en_i(spm_rx_en_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] miso_data[$];
    logic [7:0] mosi_q[$];
    logic [7:0] got_q[$];
    int cyc = 0, tx_cnt = 0, done_cnt = 0, proto_err = 0, cs_cycles = 0;
    int last_hs = 0, done_cyc = 0;
    bit ready_en = 1'b1;
    bit ready_rand = 1'b0;

    logic m_inflight = 1'b0;
    int   m_lat = 0;
    int   m_nbyte = 0;

    // spi_master stand-in: one byte in flight, random turnaround, cleared by chip-select release.
    always @(posedge clk) begin
        spm_rx_en_i <= 1'b0;
        if (!resetn || !spm_target_en_o) begin
            m_inflight     <= 1'b0;
            m_nbyte        <= 0;
            m_lat          <= 0;
            spm_tx_ready_i <= 1'b0;
        end else if (m_inflight) begin
            if (m_lat == 0) begin
                spm_rx_en_i <= 1'b1;
                if (m_nbyte >= HDR && (m_nbyte - HDR) < miso_data.size())
                    spm_rx_byte_i <= miso_data[m_nbyte - HDR];
                else
                    spm_rx_byte_i <= 8'($urandom);
                m_nbyte        <= m_nbyte + 1;
                m_inflight     <= 1'b0;
                spm_tx_ready_i <= ($urandom_range(0, 3) != 0);
            end else begin
                m_lat <= m_lat - 1;
            end
        end else if (spm_tx_en_o) begin
            m_inflight     <= 1'b1;
            m_lat          <= $urandom_range(0, 3);
            spm_tx_ready_i <= 1'b0;
        end else begin
            spm_tx_ready_i <= ($urandom_range(0, 3) != 0);
        end
    end

    always @(posedge clk) begin
        data_ready_i <= ready_en && (!ready_rand || $urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
        cyc++;
        if (spm_tx_en_o) begin
            mosi_q.push_back(spm_tx_byte_o);
            tx_cnt++;
            if (!spm_tx_ready_i || m_inflight || !spm_target_en_o) proto_err++;
        end
        if (data_valid_o && data_ready_i) begin
            got_q.push_back(data_o);
            last_hs = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (spm_target_en_o) cs_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        mosi_q.delete();
        got_q.delete();
        done_cnt  = 0;
        proto_err = 0;
        cs_cycles = 0;
    endtask

    task automatic run_txn(input logic [23:0] a, input logic [15:0] n,
                           input bit stall, input bit poke, input bit fixed);
        logic [7:0] exp_mosi[$];
        int t;
        int snap;
        miso_data.delete();
        for (int i = 0; i < int'(n); i++)
            miso_data.push_back(fixed ? 8'(8'hA1 + i) : 8'($urandom));
        if (n != 0) begin
            exp_mosi.push_back(CMD);
            exp_mosi.push_back(a[23:16]);
            exp_mosi.push_back(a[15:8]);
            exp_mosi.push_back(a[7:0]);
            if (HDR == 5) exp_mosi.push_back(8'h00);
            for (int i = 0; i < int'(n); i++) exp_mosi.push_back(8'h00);
        end
        clear_logs();
        if (stall) ready_en = 1'b0;

        @(posedge clk); #1;
        start_i = 1'b1; addr_i = a; len_i = n;
        @(posedge clk); #1;
        start_i = 1'b0; addr_i = 24'($urandom); len_i = 16'($urandom);
        if (n != 0) begin
            chk("busy_rise", busy_o, 1);
            chk("cs_rise", spm_target_en_o, 1);
        end else begin
            chk("zero_done_next", done_o, 1);
            chk("zero_busy", busy_o, 0);
        end

        if (poke) begin
            start_i = 1'b1; addr_i = 24'hABCDEF; len_i = 16'd2;
            @(posedge clk); #1;
            start_i = 1'b0;
        end

        if (stall) begin
            t = 0;
            while (!data_valid_o && t < 2000) begin @(posedge clk); #1; t++; end
            chk("stall_wait_timeout", (t < 2000), 1);
            snap = tx_cnt;
            repeat (50) @(posedge clk);
            #1;
            chk("stall_no_tx", tx_cnt - snap, 0);
            chk("stall_hold_valid", data_valid_o, 1);
            ready_en = 1'b1;
        end

        t = 0;
        while (done_cnt == 0 && t < 3000) begin @(posedge clk); #1; t++; end
        chk("done_timeout", (done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;

        chk("done_once", done_cnt, 1);
        chk("busy_after", busy_o, 0);
        chk("cs_after", spm_target_en_o, 0);
        chk("proto", proto_err, 0);
        chk("mosi_len", mosi_q.size(), exp_mosi.size());
        for (int i = 0; i < exp_mosi.size() && i < mosi_q.size(); i++)
            chk($sformatf("mosi[%0d]", i), mosi_q[i], exp_mosi[i]);
        chk("data_len", got_q.size(), int'(n));
        for (int i = 0; i < int'(n) && i < got_q.size(); i++)
            chk($sformatf("data[%0d]", i), got_q[i], miso_data[i]);
        if (n != 0) chk("done_after_handshake", done_cyc - last_hs, 1);
        else        chk("zero_cs_never", cs_cycles, 0);
    endtask

    initial begin
        int t;
        resetn = 1'b0; start_i = 1'b0; addr_i = 24'h0; len_i = 16'h0; abort_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", data_valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_cs", spm_target_en_o, 0);
        chk("rst_tx_en", spm_tx_en_o, 0);
        chk("rst_tx_byte", spm_tx_byte_o, 0);
        chk("target_id", spm_target_id_o, 2'b10);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        run_txn(24'h123456, 16'd3, 1'b0, 1'b0, 1'b1);
        run_txn(24'h000000, 16'd0, 1'b0, 1'b0, 1'b0);
        run_txn(24'h00F00D, 16'd4, 1'b1, 1'b0, 1'b0);

        clear_logs();
        @(posedge clk); #1;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("idle_abort_ignored", done_o, 0);

        clear_logs();
        miso_data.delete();
        @(posedge clk); #1;
        start_i = 1'b1; addr_i = 24'h654321; len_i = 16'd6;
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 0;
        while (mosi_q.size() < 3 && t < 500) begin @(posedge clk); #1; t++; end
        chk("abort_reach_timeout", (t < 500), 1);
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("abort_cs", spm_target_en_o, 0);
        chk("abort_done", done_o, 1);
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", data_valid_o, 0);
        @(posedge clk); #1;
        chk("abort_done_pulse", done_o, 0);
        repeat (3) @(posedge clk);
        run_txn(24'h0A0B0C, 16'd1, 1'b0, 1'b0, 1'b0);

        run_txn(24'h3C5A7E, 16'd3, 1'b0, 1'b1, 1'b0);

        ready_rand = 1'b1;
        for (int k = 0; k < 6; k++)
            run_txn(24'($urandom), 16'($urandom_range(1, 8)), 1'b0, 1'b0, 1'b0);
        ready_rand = 1'b0;

        clear_logs();
        miso_data.delete();
        for (int i = 0; i < 5; i++) miso_data.push_back(8'($urandom));
        @(posedge clk); #1;
        start_i = 1'b1; addr_i = 24'h112233; len_i = 16'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 0;
        while (got_q.size() < 1 && t < 1000) begin @(posedge clk); #1; t++; end
        chk("reset_reach_timeout", (t < 1000), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_valid", data_valid_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_cs", spm_target_en_o, 0);
        chk("mid_rst_tx_en", spm_tx_en_o, 0);
        chk("mid_rst_tx_byte", spm_tx_byte_o, 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        run_txn(24'hFEDCBA, 16'd2, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
